// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   state_e   : RAM access FSM encodings (ST_IDLE, ST_WAIT)
//   npc_src_e : next-PC source select carried down from decode
//   wb_src_e  : write-back data source (ALU result or RAM load data)
//   branch_taken() : resolves whether a retiring instruction redirects fetch
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NPC_SEQ  = 2'd0,
        NPC_JUMP = 2'd1,
        NPC_BEQZ = 2'd2,
        NPC_BNEZ = 2'd3
    } npc_src_e;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_RAM = 1'b1
    } wb_src_e;

    function automatic logic branch_taken(input logic [1:0] src, input logic zero);
        return (src == NPC_JUMP)
             | ((src == NPC_BEQZ) &  zero)
             | ((src == NPC_BNEZ) & ~zero);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-RAM request/acknowledge port.
//   master : the MEM stage (drives ram_req/ram_we/ram_addr/ram_wdata, receives ram_ack/ram_rdata)
//   slave  : the RAM (receives the request, returns ram_ack/ram_rdata)
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_ack;
    logic [31:0]       ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_ack, ram_rdata
    );
endinterface

// File: rtl/mem_access_stage_ram_access_fsm.sv
// RAM access controller for the MEM stage: decides when the EX/MEM instruction
// retires, issues the registered RAM request, and times out a silent RAM.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid .. ram_wren EX/MEM fields needed to classify and launch the access
//   ram                  RAM port (master side)
//   stall                combinational: hold EX/MEM while an access is pending
//   retire               combinational: the wb_* registers load at this edge
//   retire_wren          register-write permission for the retiring instruction
//   misaligned_err       registered one-cycle pulse for a misaligned memory op
//   bus_err              sticky until reset: the RAM never acknowledged
module ram_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        rs2_data,
    input  logic [31:0]        alu_rd_result,
    input  logic               reg_write_data_src,
    input  logic               reg_wren,
    input  logic               ram_wren,
    mem_access_stage_if.master ram,
    output logic               stall,
    output logic               retire,
    output logic               retire_wren,
    output logic               misaligned_err,
    output logic               bus_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              misaligned_err_q, misaligned_err_d;
    logic              bus_err_q, bus_err_d;

    logic mem_op;
    logic misaligned;

    assign mem_op     = in_valid & (ram_wren | reg_write_data_src);
    assign misaligned = (alu_rd_result[1:0] != 2'b00);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; an unassigned path would infer a latch.
        state_d          = state_q;
        cnt_d            = cnt_q;
        ram_req_d        = ram_req_q;
        ram_we_d         = ram_we_q;
        ram_addr_d       = ram_addr_q;
        ram_wdata_d      = ram_wdata_q;
        misaligned_err_d = 1'b0;
        bus_err_d        = bus_err_q;
        stall            = 1'b0;
        retire           = 1'b0;
        retire_wren      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!mem_op) begin
                        retire      = 1'b1;
                        retire_wren = reg_wren;
                    end else if (misaligned) begin
                        // Dropped without touching the RAM; retires as a bubble.
                        retire           = 1'b1;
                        misaligned_err_d = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        ram_req_d   = 1'b1;
                        ram_we_d    = ram_wren;
                        ram_addr_d  = {alu_rd_result[ADDR_W-1:2], 2'b00};
                        ram_wdata_d = rs2_data;
                        cnt_d       = '0;
                        state_d     = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall = ~ram.ram_ack;
                cnt_d = cnt_q + CNT_W'(1);
                if (ram.ram_ack) begin
                    ram_req_d   = 1'b0;
                    ram_we_d    = 1'b0;
                    retire      = 1'b1;
                    retire_wren = reg_wren & ~ram_wren;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: the instruction retires now, so EX/MEM must be
                    // released this cycle or it would be issued a second time.
                    stall     = 1'b0;
                    ram_req_d = 1'b0;
                    ram_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    retire    = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: address/data registers are reset too, because the RAM port is
        // required to read all-zero coming out of reset, not just ram_req.
        if (reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            ram_req_q        <= 1'b0;
            ram_we_q         <= 1'b0;
            ram_addr_q       <= '0;
            ram_wdata_q      <= '0;
            misaligned_err_q <= 1'b0;
            bus_err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its _d
            // value from before this edge, independent of statement order.
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            ram_req_q        <= ram_req_d;
            ram_we_q         <= ram_we_d;
            ram_addr_q       <= ram_addr_d;
            ram_wdata_q      <= ram_wdata_d;
            misaligned_err_q <= misaligned_err_d;
            bus_err_q        <= bus_err_d;
        end
    end

    assign ram.ram_req    = ram_req_q;
    assign ram.ram_we     = ram_we_q;
    assign ram.ram_addr   = ram_addr_q;
    assign ram.ram_wdata  = ram_wdata_q;
    assign misaligned_err = misaligned_err_q;
    assign bus_err        = bus_err_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: consumes the frozen EX/MEM fields, performs the data-RAM
// access through ram_access_fsm, and registers the MEM/WB entry plus the
// next-PC redirect.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid .. ram_wren       EX/MEM register fields
//   stall                      combinational; EX/MEM wren = ~stall
//   ram                        data-RAM port (master side)
//   wb_*                       MEM/WB register (valid, rd, data, reg write enable)
//   redirect_valid/pc          one-cycle fetch redirect on a taken branch/jump
//   misaligned_err, bus_err    error indications from the access controller
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        pc_data,
    input  logic [31:0]        rs2_data,
    input  logic [4:0]         rd_address,
    input  logic [31:0]        alu_rd_result,
    input  logic               alu_rd_result_is_zero,
    input  logic [31:0]        alu_pc_result,
    input  logic [1:0]         next_pc_src,
    input  logic               reg_write_data_src,
    input  logic               reg_wren,
    input  logic               ram_wren,
    output logic               stall,
    mem_access_stage_if.master ram,
    output logic               wb_valid,
    output logic [4:0]         wb_rd_address,
    output logic [31:0]        wb_write_data,
    output logic               wb_reg_wren,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               misaligned_err,
    output logic               bus_err
);

    logic retire;
    logic retire_wren;

    // Branch/jump targets arrive precomputed on alu_pc_result, so the
    // instruction PC itself is not consumed here.
    logic unused_pc;
    assign unused_pc = ^pc_data;

    ram_access_fsm #(
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_fsm (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .rs2_data           (rs2_data),
        .alu_rd_result      (alu_rd_result),
        .reg_write_data_src (reg_write_data_src),
        .reg_wren           (reg_wren),
        .ram_wren           (ram_wren),
        .ram                (ram),
        .stall              (stall),
        .retire             (retire),
        .retire_wren        (retire_wren),
        .misaligned_err     (misaligned_err),
        .bus_err            (bus_err)
    );

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_address_q, wb_rd_address_d;
    logic [31:0] wb_write_data_q, wb_write_data_d;
    logic        wb_reg_wren_q, wb_reg_wren_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    always_comb begin
        // Non-retire cycles are bubbles: valid and write enable always drop.
        wb_valid_d       = retire;
        wb_reg_wren_d    = retire & retire_wren;
        wb_rd_address_d  = wb_rd_address_q;
        wb_write_data_d  = wb_write_data_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (retire) begin
            wb_rd_address_d = rd_address;
            wb_write_data_d = (wb_src_e'(reg_write_data_src) == WB_SRC_RAM) ? ram.ram_rdata
                                                                           : alu_rd_result;
            if (branch_taken(next_pc_src, alu_rd_result_is_zero)) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = alu_pc_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q       <= 1'b0;
            wb_rd_address_q  <= '0;
            wb_write_data_q  <= '0;
            wb_reg_wren_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            wb_valid_q       <= wb_valid_d;
            wb_rd_address_q  <= wb_rd_address_d;
            wb_write_data_q  <= wb_write_data_d;
            wb_reg_wren_q    <= wb_reg_wren_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign wb_valid       = wb_valid_q;
    assign wb_rd_address  = wb_rd_address_q;
    assign wb_write_data  = wb_write_data_q;
    assign wb_reg_wren    = wb_reg_wren_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage. Stimulus tasks push the expected MEM/WB
// entry into a queue; an independent negedge monitor pops and compares each
// time wb_valid is seen. Port-level timing checks live in the stimulus tasks.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int ADDR_W      = 32;
    localparam int ACK_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] pc_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_address;
    logic [31:0] alu_rd_result;
    logic        alu_rd_result_is_zero;
    logic [31:0] alu_pc_result;
    logic [1:0]  next_pc_src;
    logic        reg_write_data_src;
    logic        reg_wren;
    logic        ram_wren;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd_address;
    logic [31:0] wb_write_data;
    logic        wb_reg_wren;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned_err;
    logic        bus_err;

    mem_access_stage_if #(.ADDR_W(ADDR_W)) ram_if ();

    mem_access_stage #(
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_valid              (in_valid),
        .pc_data               (pc_data),
        .rs2_data              (rs2_data),
        .rd_address            (rd_address),
        .alu_rd_result         (alu_rd_result),
        .alu_rd_result_is_zero (alu_rd_result_is_zero),
        .alu_pc_result         (alu_pc_result),
        .next_pc_src           (next_pc_src),
        .reg_write_data_src    (reg_write_data_src),
        .reg_wren              (reg_wren),
        .ram_wren              (ram_wren),
        .stall                 (stall),
        .ram                   (ram_if),
        .wb_valid              (wb_valid),
        .wb_rd_address         (wb_rd_address),
        .wb_write_data         (wb_write_data),
        .wb_reg_wren           (wb_reg_wren),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .misaligned_err        (misaligned_err),
        .bus_err               (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        wren;
        logic        redir;
        logic [31:0] rpc;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    exp_t mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_valid) begin
                check("wb_entry_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wb_rd_address", 32'(wb_rd_address), 32'(mon_e.rd));
                    check("wb_reg_wren", 32'(wb_reg_wren), 32'(mon_e.wren));
                    check("redirect_valid", 32'(redirect_valid), 32'(mon_e.redir));
                    check("misaligned_err", 32'(misaligned_err), 32'(mon_e.mis));
                    if (mon_e.chk_data) check("wb_write_data", wb_write_data, mon_e.data);
                    if (mon_e.redir) check("redirect_pc", redirect_pc, mon_e.rpc);
                end
            end else begin
                check("quiet_without_retire",
                      {29'd0, wb_reg_wren, redirect_valid, misaligned_err}, 32'd0);
            end
        end
    end

    task automatic idle_inputs();
        in_valid              = 1'b0;
        pc_data               = '0;
        rs2_data              = '0;
        rd_address            = '0;
        alu_rd_result         = '0;
        alu_rd_result_is_zero = 1'b0;
        alu_pc_result         = '0;
        next_pc_src           = NPC_SEQ;
        reg_write_data_src    = WB_SRC_ALU;
        reg_wren              = 1'b0;
        ram_wren              = 1'b0;
        ram_if.ram_ack        = 1'b0;
        ram_if.ram_rdata      = '0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic chk_data,
                        input logic wren, input logic redir, input logic [31:0] rpc,
                        input logic mis);
        exp_t e;
        e.rd = rd; e.data = data; e.chk_data = chk_data; e.wren = wren;
        e.redir = redir; e.rpc = rpc; e.mis = mis;
        exp_q.push_back(e);
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] alu, input logic wren,
                           input logic [1:0] src, input logic zero, input logic [31:0] tgt);
        in_valid              = 1'b1;
        pc_data               = 32'h0000_1000;
        rd_address            = rd;
        alu_rd_result         = alu;
        reg_wren              = wren;
        next_pc_src           = src;
        alu_rd_result_is_zero = zero;
        alu_pc_result         = tgt;
        reg_write_data_src    = WB_SRC_ALU;
        ram_wren              = 1'b0;
    endtask

    // Non-memory op: one-cycle latency, no stall. exp_redir is hand-derived.
    task automatic alu_op(input logic [4:0] rd, input logic [31:0] alu, input logic wren,
                          input logic [1:0] src, input logic zero, input logic [31:0] tgt,
                          input logic exp_redir);
        @(posedge clk); #1;
        set_alu(rd, alu, wren, src, zero, tgt);
        push(rd, alu, 1'b1, wren, exp_redir, tgt, 1'b0);
        @(negedge clk);
        check("alu_no_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("alu_latency_wb_valid", 32'(wb_valid), 32'd1);
    endtask

    // Aligned load/store with ram_ack raised ack_delay cycles after ram_req.
    task automatic mem_op(input logic [31:0] addr, input logic is_store, input logic [31:0] wdata,
                          input int ack_delay, input logic [31:0] rdata, input logic [4:0] rd);
        int stall_cycles = 0;
        @(posedge clk); #1;
        in_valid           = 1'b1;
        rd_address         = rd;
        alu_rd_result      = addr;
        rs2_data           = wdata;
        reg_wren           = 1'b1;
        ram_wren           = is_store;
        reg_write_data_src = is_store ? WB_SRC_ALU : WB_SRC_RAM;
        next_pc_src        = NPC_SEQ;
        push(rd, is_store ? addr : rdata, 1'b1, ~is_store, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        stall_cycles += int'(stall);
        check("mem_req_not_yet", 32'(ram_if.ram_req), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < ack_delay; k++) begin
            @(negedge clk);
            stall_cycles += int'(stall);
            check("mem_req_held", 32'(ram_if.ram_req), 32'd1);
            @(posedge clk); #1;
        end
        ram_if.ram_ack   = 1'b1;
        ram_if.ram_rdata = rdata;
        @(negedge clk);
        stall_cycles += int'(stall);
        check("mem_req_at_ack", 32'(ram_if.ram_req), 32'd1);
        check("mem_ram_we", 32'(ram_if.ram_we), 32'(is_store));
        check("mem_ram_addr", ram_if.ram_addr, addr);
        if (is_store) check("mem_ram_wdata", ram_if.ram_wdata, wdata);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("mem_req_dropped", 32'(ram_if.ram_req), 32'd0);
        check("mem_stall_cycles", 32'(stall_cycles), 32'(ack_delay + 1));
        check("mem_wb_valid_after_ack", 32'(wb_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  req_cycles;
        bit  done;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ram_req", 32'(ram_if.ram_req), 32'd0);
        check("rst_ram_we", 32'(ram_if.ram_we), 32'd0);
        check("rst_ram_addr", ram_if.ram_addr, 32'd0);
        check("rst_ram_wdata", ram_if.ram_wdata, 32'd0);
        check("rst_wb", {26'd0, wb_valid, wb_reg_wren, 4'd0} | {27'd0, wb_rd_address}, 32'd0);
        check("rst_wb_data", wb_write_data, 32'd0);
        check("rst_redirect", {31'd0, redirect_valid} | redirect_pc, 32'd0);
        check("rst_errors", {30'd0, misaligned_err, bus_err}, 32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Plain ALU op.
        alu_op(5'd5, 32'h0000_1234, 1'b1, NPC_SEQ, 1'b0, 32'h0, 1'b0);
        // Load, ack three cycles after the request; then store acked at once.
        mem_op(32'h0000_0100, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 5'd6);
        mem_op(32'h0000_0040, 1'b1, 32'hA5A5_A5A5, 0, 32'h0, 5'd8);
        // Branch resolution table.
        alu_op(5'd0, 32'h0000_0000, 1'b0, NPC_BEQZ, 1'b1, 32'h0000_0080, 1'b1);
        alu_op(5'd0, 32'h0000_0001, 1'b0, NPC_BEQZ, 1'b0, 32'h0000_0080, 1'b0);
        alu_op(5'd0, 32'h0000_0003, 1'b0, NPC_BNEZ, 1'b0, 32'h0000_0C00, 1'b1);
        alu_op(5'd0, 32'h0000_0000, 1'b0, NPC_BNEZ, 1'b1, 32'h0000_0C00, 1'b0);
        alu_op(5'd1, 32'h0000_2004, 1'b1, NPC_JUMP, 1'b0, 32'h0000_0200, 1'b1);
        alu_op(5'd2, 32'h0000_0000, 1'b1, NPC_SEQ, 1'b1, 32'h0000_0300, 1'b0);

        // Misaligned load (stray ack must be ignored), then back-to-back ALU op.
        @(posedge clk); #1;
        in_valid           = 1'b1;
        rd_address         = 5'd3;
        alu_rd_result      = 32'h0000_0102;
        reg_wren           = 1'b1;
        reg_write_data_src = WB_SRC_RAM;
        ram_if.ram_ack     = 1'b1;
        push(5'd3, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("mis_no_stall", 32'(stall), 32'd0);
        check("mis_no_req", 32'(ram_if.ram_req), 32'd0);
        @(posedge clk); #1;
        ram_if.ram_ack = 1'b0;
        set_alu(5'd7, 32'h0000_0055, 1'b1, NPC_SEQ, 1'b0, 32'h0);
        push(5'd7, 32'h0000_0055, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("mis_retired", 32'(wb_valid), 32'd1);
        check("mis_still_no_req", 32'(ram_if.ram_req), 32'd0);
        check("b2b_no_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("b2b_wb_valid", 32'(wb_valid), 32'd1);

        // Load that is never acknowledged: abort after ACK_TIMEOUT cycles.
        @(posedge clk); #1;
        in_valid           = 1'b1;
        rd_address         = 5'd9;
        alu_rd_result      = 32'h0000_0200;
        reg_wren           = 1'b1;
        reg_write_data_src = WB_SRC_RAM;
        push(5'd9, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        req_cycles = 0;
        done       = 1'b0;
        for (int c = 0; c < 4 * ACK_TIMEOUT && !done; c++) begin
            @(negedge clk);
            if (ram_if.ram_req) req_cycles++;
            if (!stall) done = 1'b1;
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        check("to_released", 32'(done), 32'd1);
        check("to_req_cycles", 32'(req_cycles), 32'(ACK_TIMEOUT));
        check("to_req_dropped", 32'(ram_if.ram_req), 32'd0);
        check("to_bus_err", 32'(bus_err), 32'd1);
        alu_op(5'd10, 32'h0000_00AA, 1'b1, NPC_SEQ, 1'b0, 32'h0, 1'b0);
        check("bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset in the middle of a WAIT.
        @(posedge clk); #1;
        in_valid           = 1'b1;
        rd_address         = 5'd11;
        alu_rd_result      = 32'h0000_0300;
        reg_wren           = 1'b1;
        reg_write_data_src = WB_SRC_RAM;
        @(posedge clk); #1;
        @(negedge clk);
        check("rw_req_before_reset", 32'(ram_if.ram_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rw_req_cleared", 32'(ram_if.ram_req), 32'd0);
        check("rw_bus_err_cleared", 32'(bus_err), 32'd0);
        check("rw_no_retire", 32'(wb_valid), 32'd0);
        alu_op(5'd12, 32'h0000_0777, 1'b1, NPC_SEQ, 1'b0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
